// File: rtl/ff_array_pkg.sv
// ff_array_pkg: shared types and helpers for the ff_array block.
//   mode_t   - operating-mode encoding sampled on the 2-bit mode port
//   jk_apply - one-bit JK next-state rule, shared by the cell and the
//              next-state predictor in the top
package ff_array_pkg;

  typedef enum logic [1:0] {
    MODE_JK  = 2'b00,
    MODE_T   = 2'b01,
    MODE_SR  = 2'b10,
    MODE_CNT = 2'b11
  } mode_t;

  // Next value of a single JK bit: 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic jk_apply(input logic q_cur, input logic j_in, input logic k_in);
    logic nxt;
    case ({j_in, k_in})
      2'b00:   nxt = q_cur;
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      2'b11:   nxt = ~q_cur;
      default: nxt = q_cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ff_array_jk_cell.sv
// jk_cell: one-bit JK flip-flop with parallel load.
//   clk     - rising-edge clock
//   reset   - asynchronous active-high reset, loads RST_VAL
//   load, d - parallel load; overrides j/k when load=1
//   j, k    - JK inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   q       - registered state
module jk_cell
  import ff_array_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic d,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_r;

  // State bit: reset value, else load, else JK rule.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= RST_VAL;
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= jk_apply(q_r, j, k);
    end
  end

  assign q = q_r;

endmodule

// File: rtl/ff_array.sv
// ff_array: WIDTH-bit flip-flop array built from jk_cell instances. Each
// mode is translated into per-bit {j,k} drive for the cells.
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset (q=RESET_VAL, flags cleared)
//   en       - enables the mode-driven update
//   mode     - 00 JK, 01 T, 10 SR, 11 COUNT
//   j, k     - per-bit J/T/S and K/R inputs
//   load, d  - parallel load, has priority over en
//   up       - COUNT direction (1 up, 0 down)
//   q, qbar  - registered state and its combinational complement
//   tc       - registered pulse on a COUNT wrap edge
//   changed  - registered flag, q changed on the last edge
//   err      - sticky SR-conflict flag, cleared by load
module ff_array
  import ff_array_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             changed,
  output logic             err
);

  mode_t            mode_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] carry_s;
  logic [WIDTH-1:0] cj_s;
  logic [WIDTH-1:0] ck_s;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_s;
  logic             sr_conflict_s;
  logic             tc_r;
  logic             changed_r;
  logic             err_r;

  assign mode_s = mode_t'(mode);

  // Toggle chain for COUNT: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    carry_s    = {WIDTH{1'b0}};
    carry_s[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      if (up) begin
        carry_s[i] = carry_s[i-1] & q_s[i-1];
      end else begin
        carry_s[i] = carry_s[i-1] & ~q_s[i-1];
      end
    end
  end

  // A wrap happens when every bit toggles: all-ones going up, all-zeros going down.
  assign wrap_s = up ? (&q_s) : ~(|q_s);

  // Map the selected mode onto per-bit {j,k}; en=0 forces hold.
  always_comb begin
    cj_s = {WIDTH{1'b0}};
    ck_s = {WIDTH{1'b0}};
    if (en) begin
      case (mode_s)
        MODE_JK: begin
          cj_s = j;
          ck_s = k;
        end
        MODE_T: begin
          cj_s = j;
          ck_s = j;
        end
        MODE_SR: begin
          // S=R=1 is a conflict: mask both to hold the bit.
          cj_s = j & ~k;
          ck_s = k & ~j;
        end
        MODE_CNT: begin
          cj_s = carry_s;
          ck_s = carry_s;
        end
        default: begin
          cj_s = {WIDTH{1'b0}};
          ck_s = {WIDTH{1'b0}};
        end
      endcase
    end else begin
      cj_s = {WIDTH{1'b0}};
      ck_s = {WIDTH{1'b0}};
    end
  end

  assign sr_conflict_s = en && (mode_s == MODE_SR) && (|(j & k));

  // Predict the value the cells will take, used only for the changed flag.
  always_comb begin
    q_next_s = q_s;
    if (load) begin
      q_next_s = d;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        q_next_s[i] = jk_apply(q_s[i], cj_s[i], ck_s[i]);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell #(
        .RST_VAL (RESET_VAL[gi])
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (d[gi]),
        .j     (cj_s[gi]),
        .k     (ck_s[gi]),
        .q     (q_s[gi])
      );
    end
  endgenerate

  // Status flags: terminal count, changed, and sticky SR error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc_r      <= 1'b0;
      changed_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      changed_r <= (q_next_s != q_s);
      if (load) begin
        tc_r  <= 1'b0;
        err_r <= 1'b0;
      end else begin
        tc_r  <= en && (mode_s == MODE_CNT) && wrap_s;
        err_r <= err_r | sr_conflict_s;
      end
    end
  end

  assign q       = q_s;
  assign qbar    = ~q_s;
  assign tc      = tc_r;
  assign changed = changed_r;
  assign err     = err_r;

endmodule

// File: tb/tb_ff_array.sv
// tb_ff_array: directed-vector bench for ff_array with WIDTH=4, RESET_VAL=0.
module tb_ff_array;
  import ff_array_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         load;
  logic [W-1:0] d;
  logic         up;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;
  logic         changed;
  logic         err;

  int total_cnt;
  int bad_cnt;

  ff_array #(
    .WIDTH     (W),
    .RESET_VAL (4'h0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .load    (load),
    .d       (d),
    .up      (up),
    .q       (q),
    .qbar    (qbar),
    .tc      (tc),
    .changed (changed),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one set of inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic l, input logic [W-1:0] dv, input logic e,
                      input logic [1:0] m, input logic [W-1:0] jv,
                      input logic [W-1:0] kv, input logic u);
    load = l; d = dv; en = e; mode = m; j = jv; k = kv; up = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset = 1'b1; en = 1'b0; mode = 2'b00; j = 4'h0; k = 4'h0;
    load = 1'b0; d = 4'h0; up = 1'b1;
    #12;
    check_eq("rst_q",    {28'h0, q},    32'h0);
    check_eq("rst_qbar", {28'h0, qbar}, 32'hF);
    check_eq("rst_flags", {29'h0, tc, changed, err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Load A, then reset between edges.
    step(1'b1, 4'hA, 1'b0, MODE_JK, 4'h0, 4'h0, 1'b1);
    check_eq("load_a_q", {28'h0, q}, 32'hA);
    check_eq("load_a_changed", {31'h0, changed}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_q",    {28'h0, q},    32'h0);
    check_eq("async_rst_qbar", {28'h0, qbar}, 32'hF);
    check_eq("async_rst_flags", {29'h0, tc, changed, err}, 32'h0);
    #1;
    reset = 1'b0;

    // First edge after reset runs normally from 0.
    step(1'b0, 4'h0, 1'b1, MODE_CNT, 4'h0, 4'h0, 1'b1);
    check_eq("post_rst_cnt", {28'h0, q}, 32'h1);

    // JK: 0101 with j=1100 k=1010 -> 1101.
    step(1'b1, 4'h5, 1'b0, MODE_JK, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1, MODE_JK, 4'hC, 4'hA, 1'b1);
    check_eq("jk_q", {28'h0, q}, 32'hD);
    check_eq("jk_changed", {31'h0, changed}, 32'h1);
    check_eq("jk_qbar", {28'h0, qbar}, 32'h2);

    // COUNT up E -> F -> 0 -> 1.
    step(1'b1, 4'hE, 1'b0, MODE_JK, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1, MODE_CNT, 4'h0, 4'h0, 1'b1);
    check_eq("up_f_q", {28'h0, q}, 32'hF);
    check_eq("up_f_tc", {31'h0, tc}, 32'h0);
    step(1'b0, 4'h0, 1'b1, MODE_CNT, 4'h0, 4'h0, 1'b1);
    check_eq("up_wrap_q", {28'h0, q}, 32'h0);
    check_eq("up_wrap_tc", {31'h0, tc}, 32'h1);
    step(1'b0, 4'h0, 1'b1, MODE_CNT, 4'h0, 4'h0, 1'b1);
    check_eq("up_1_q", {28'h0, q}, 32'h1);
    check_eq("up_1_tc", {31'h0, tc}, 32'h0);

    // COUNT down 0 -> F with tc, then F -> E.
    step(1'b1, 4'h0, 1'b0, MODE_JK, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1, MODE_CNT, 4'h0, 4'h0, 1'b0);
    check_eq("dn_wrap_q", {28'h0, q}, 32'hF);
    check_eq("dn_wrap_tc", {31'h0, tc}, 32'h1);
    step(1'b0, 4'h0, 1'b1, MODE_CNT, 4'h0, 4'h0, 1'b0);
    check_eq("dn_e_q", {28'h0, q}, 32'hE);
    check_eq("dn_e_tc", {31'h0, tc}, 32'h0);

    // Wrap then load: tc must drop on the load edge.
    step(1'b1, 4'hF, 1'b0, MODE_JK, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1, MODE_CNT, 4'h0, 4'h0, 1'b1);
    check_eq("wrap2_tc", {31'h0, tc}, 32'h1);
    step(1'b1, 4'h9, 1'b1, MODE_CNT, 4'h0, 4'h0, 1'b1);
    check_eq("load_tc", {31'h0, tc}, 32'h0);
    check_eq("load_q", {28'h0, q}, 32'h9);

    // SR: q=0, j=0011 k=0110 -> 0001, err sticky, load clears it.
    step(1'b1, 4'h0, 1'b0, MODE_JK, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1, MODE_SR, 4'h3, 4'h6, 1'b1);
    check_eq("sr_q", {28'h0, q}, 32'h1);
    check_eq("sr_err", {31'h0, err}, 32'h1);
    step(1'b0, 4'h0, 1'b1, MODE_SR, 4'h0, 4'h0, 1'b1);
    check_eq("sr_err_sticky", {31'h0, err}, 32'h1);
    check_eq("sr_hold_changed", {31'h0, changed}, 32'h0);
    step(1'b1, 4'h5, 1'b1, MODE_SR, 4'h3, 4'h6, 1'b1);
    check_eq("sr_load_q", {28'h0, q}, 32'h5);
    check_eq("sr_load_err", {31'h0, err}, 32'h0);

    // Load beats COUNT, then en=0 holds.
    step(1'b1, 4'h3, 1'b1, MODE_CNT, 4'h0, 4'h0, 1'b1);
    check_eq("cnt_load_q", {28'h0, q}, 32'h3);
    check_eq("cnt_load_tc", {31'h0, tc}, 32'h0);
    step(1'b0, 4'h0, 1'b0, MODE_CNT, 4'hF, 4'hF, 1'b1);
    check_eq("hold_q", {28'h0, q}, 32'h3);
    check_eq("hold_changed", {31'h0, changed}, 32'h0);

    // T mode: F with j=F -> 0, then j=0 holds; k is ignored.
    step(1'b1, 4'hF, 1'b0, MODE_JK, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1, MODE_T, 4'hF, 4'h0, 1'b1);
    check_eq("t_q", {28'h0, q}, 32'h0);
    check_eq("t_changed", {31'h0, changed}, 32'h1);
    step(1'b0, 4'h0, 1'b1, MODE_T, 4'h0, 4'hF, 1'b1);
    check_eq("t_hold_q", {28'h0, q}, 32'h0);
    check_eq("t_hold_changed", {31'h0, changed}, 32'h0);
    step(1'b0, 4'h0, 1'b1, MODE_T, 4'h5, 4'hA, 1'b1);
    check_eq("t_k_ignored", {28'h0, q}, 32'h5);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/ff_array.md
FF_ARRAY -- requirements
Module: ff_array

Interface
REQ-001 Parameter WIDTH, default 8, number of flip-flop bits (legal range 1..32).
REQ-002 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  update enable for mode-driven operation.
REQ-006 mode  in  2  operating mode: 00 JK, 01 T, 10 SR, 11 COUNT.
REQ-007 j  in  WIDTH  per-bit J / T / S input, depending on mode.
REQ-008 k  in  WIDTH  per-bit K / R input; ignored in T and COUNT modes.
REQ-009 load  in  1  parallel load strobe.
REQ-010 d  in  WIDTH  parallel load data.
REQ-011 up  in  1  count direction in COUNT mode: 1 up, 0 down.
REQ-012 q  out  WIDTH  registered state.
REQ-013 qbar  out  WIDTH  combinational ~q.
REQ-014 tc  out  1  registered terminal-count pulse.
REQ-015 changed  out  1  registered flag: q changed on the last edge.
REQ-016 err  out  1  sticky SR-conflict flag.

Function
REQ-017 Latency is one clock: inputs sampled on a rising edge appear on q after that edge; there is no pipelining.
REQ-018 Priority is load over en: load=1 sets q<=d regardless of en and mode.
REQ-019 With load=0 and en=0, q holds, and tc<=0 and changed<=0.
REQ-020 JK mode, per bit {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-021 T mode, per bit: j=1 toggles the bit; j=0 holds it.
REQ-022 SR mode, per bit: 10 set, 01 clear, 00 hold; 11 holds the bit and sets err.
REQ-023 COUNT mode, up=1: bit i toggles when bits i-1..0 are all 1; bit 0 always toggles (binary increment).
REQ-024 COUNT mode, up=0: bit i toggles when bits i-1..0 are all 0 (binary decrement).
REQ-025 COUNT wrap-around: up from all-ones goes to 0, and down from 0 goes to all-ones; tc<=1 on that edge only.
REQ-026 tc is 0 on every edge that is not a COUNT wrap, including a load edge.
REQ-027 changed<=1 exactly when the next q differs from the current q, in any mode or on load.
REQ-028 err is sticky once set; load clears it, and load also wins over a simultaneous SR conflict.
REQ-029 A mode change takes effect on the first edge at which the new mode is sampled; no state is carried between modes except q.

Reset
REQ-030 While reset=1: q=RESET_VAL, qbar=~RESET_VAL, tc=0, changed=0, err=0, asynchronously and without a clock edge.
REQ-031 Reset asserted mid-operation aborts any update; the first edge after deassertion operates normally from RESET_VAL.

Structure
REQ-032 Package ff_array_pkg holds the mode typedef (MODE_JK=2'b00, MODE_T=2'b01, MODE_SR=2'b10, MODE_CNT=2'b11).
REQ-033 Sub-module jk_cell: one-bit JK flip-flop with clk, active-high async reset with per-instance reset value, load/d priority input, j, k and q.
REQ-034 The top instantiates WIDTH jk_cell instances, maps each mode onto per-bit {j,k}, and provides the count carry/borrow chain, tc, changed and err logic.

Verification (WIDTH=4, RESET_VAL=0)
REQ-035 q=4'hA, assert reset between edges -> q=0 and qbar=4'hF immediately; tc, changed and err are 0.
REQ-036 JK mode, q=4'b0101, j=4'b1100, k=4'b1010, en=1 -> q=4'b1101 and changed=1.
REQ-037 COUNT up from 4'hE -> 4'hF with tc=0, then 4'h0 with tc=1, then 4'h1 with tc=0. COUNT down from 4'h0 -> 4'hF with tc=1.
REQ-038 SR mode, q=0, j=4'b0011, k=4'b0110 -> q=4'b0001 and err=1. Next edge with load=1, d=4'h5 -> q=4'h5 and err=0.
REQ-039 COUNT mode, en=1, load=1, d=4'h3 -> q=4'h3 (no increment) and tc=0. Then en=0, load=0 -> q stays 4'h3 and changed=0.
REQ-040 T mode, q=4'hF, j=4'hF, en=1 -> q=4'h0 and changed=1. Repeating with j=0 -> q stays 4'h0 and changed=0.
